// File: rtl/ila_dump_ctrl_pkg.sv
// Shared ILA definitions: dump controller state encoding and readout word geometry.
package ila_dump_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_CAPTURE,
        ST_ADDR,
        ST_WAIT,
        ST_SEND,
        ST_DONE
    } ila_state_e;

    localparam int ILA_TIMEOUT_W = 16;

    // Readout words per sample: a sample narrower than the read port still takes one word.
    function automatic int ila_nwords(input int data_w, input int signal_w);
        return (data_w >= signal_w) ? 1 : signal_w / data_w;
    endfunction

    function automatic int ila_sel_w(input int data_w, input int signal_w);
        int n;
        n = ila_nwords(data_w, signal_w);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ila_dump_ctrl.sv
// ILA dump sequencer: soft-clears the capture core, waits for samples or timeout, then streams
// count x NWORDS words; 2 cycles index-to-dout per word, dout held stable while dout_ready is low.
module ila_dump_ctrl
    import ila_dump_ctrl_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int SIGNAL_W   = 64,
    parameter int BUFFER_W   = 10,
    parameter int SEL_W      = ila_sel_w(DATA_W, SIGNAL_W),
    parameter int CLR_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [BUFFER_W-1:0]      target,
    input  logic [ILA_TIMEOUT_W-1:0] timeout,
    output logic                     rst_soft,
    output logic [BUFFER_W-1:0]      index,
    output logic [SEL_W-1:0]         value_select,
    input  logic [BUFFER_W-1:0]      samples,
    input  logic [DATA_W-1:0]        value,
    output logic [DATA_W-1:0]        dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic                     dout_last,
    output logic                     busy,
    output logic                     done,
    output logic                     timed_out
);

    localparam int                   NWORDS   = ila_nwords(DATA_W, SIGNAL_W);
    localparam int                   CLR_W    = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [CLR_W-1:0]     CLR_LAST = CLR_W'(CLR_CYCLES - 1);
    localparam logic [SEL_W-1:0]     LAST_SEL = SEL_W'(NWORDS - 1);
    localparam logic [BUFFER_W-1:0]  ALL_ONES = '1;

    ila_state_e                 state_q;
    logic [BUFFER_W-1:0]        target_q, count_q, index_q;
    logic [SEL_W-1:0]           sel_q;
    logic [ILA_TIMEOUT_W-1:0]   timeout_q, tcnt_q, tcnt_d;
    logic [CLR_W-1:0]           clr_q;
    logic [DATA_W-1:0]          dout_q;
    logic                       rst_soft_q, dout_valid_q, dout_last_q, busy_q, done_q, timed_out_q;
    logic                       hit_d, to_hit_d, last_word_d;
    logic [BUFFER_W-1:0]        count_d;

    always_comb begin
        tcnt_d      = (tcnt_q == '1) ? tcnt_q : tcnt_q + ILA_TIMEOUT_W'(1);
        hit_d       = (samples >= target_q) || (samples == ALL_ONES);
        to_hit_d    = (timeout_q != '0) && (tcnt_d == timeout_q);
        count_d     = (samples < target_q) ? samples : target_q;
        last_word_d = (index_q == count_q - BUFFER_W'(1)) && (sel_q == LAST_SEL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            target_q     <= '0;
            count_q      <= '0;
            index_q      <= '0;
            sel_q        <= '0;
            timeout_q    <= '0;
            tcnt_q       <= '0;
            clr_q        <= '0;
            dout_q       <= '0;
            rst_soft_q   <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timed_out_q  <= 1'b0;
        end else if (abort) begin
            state_q      <= ST_IDLE;
            rst_soft_q   <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q     <= ST_CLEAR;
                        target_q    <= (target == '0) ? ALL_ONES : target;
                        timeout_q   <= timeout;
                        timed_out_q <= 1'b0;
                        tcnt_q      <= '0;
                        clr_q       <= '0;
                        rst_soft_q  <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (clr_q == CLR_LAST) begin
                        state_q    <= ST_CAPTURE;
                        rst_soft_q <= 1'b0;
                    end else begin
                        clr_q <= clr_q + CLR_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    tcnt_q <= tcnt_d;
                    // Reaching the sample target in the same cycle the timer expires is not a timeout.
                    if (hit_d || to_hit_d) begin
                        count_q     <= count_d;
                        timed_out_q <= !hit_d;
                        index_q     <= '0;
                        sel_q       <= '0;
                        if (count_d == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_ADDR;
                        end
                    end
                end
                ST_ADDR: state_q <= ST_WAIT;
                ST_WAIT: begin
                    state_q      <= ST_SEND;
                    dout_q       <= value;
                    dout_last_q  <= last_word_d;
                    dout_valid_q <= 1'b1;
                end
                ST_SEND: begin
                    if (dout_ready) begin
                        dout_valid_q <= 1'b0;
                        dout_last_q  <= 1'b0;
                        if (dout_last_q) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_ADDR;
                            if (sel_q == LAST_SEL) begin
                                sel_q   <= '0;
                                index_q <= index_q + BUFFER_W'(1);
                            end else begin
                                sel_q <= sel_q + SEL_W'(1);
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rst_soft     = rst_soft_q;
    assign index        = index_q;
    assign value_select = sel_q;
    assign dout         = dout_q;
    assign dout_valid   = dout_valid_q;
    assign dout_last    = dout_last_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign timed_out    = timed_out_q;

endmodule

// File: tb/tb_ila_dump_ctrl.sv
// Bench for ila_dump_ctrl: vector table, abort/reset sequences and random runs against a capture model.
module tb_ila_dump_ctrl;

    localparam int DW  = 32;
    localparam int SW  = 64;
    localparam int BW  = 4;
    localparam int CLR = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0, abort = 1'b0, dout_ready = 1'b0;
    logic [BW-1:0] target = '0, samples = '0, index;
    logic [15:0]   timeout = '0;
    logic          rst_soft, dout_valid, dout_last, busy, done, timed_out;
    logic [0:0]    value_select;
    logic [DW-1:0] value = '0, dout;

    ila_dump_ctrl #(
        .DATA_W(DW), .SIGNAL_W(SW), .BUFFER_W(BW), .SEL_W(1), .CLR_CYCLES(CLR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .target(target),
        .timeout(timeout), .rst_soft(rst_soft), .index(index), .value_select(value_select),
        .samples(samples), .value(value), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .dout_last(dout_last), .busy(busy), .done(done),
        .timed_out(timed_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0;
    int run_id = 0, cap_q = 0, step_q = 1, cap_k = 0, rdy_mode = 0, stall_left = 0;
    int rs_cycles = 0, done_cnt = 0;
    logic [DW-1:0] got_dat[$];
    bit            got_last[$];
    bit            prev_stall = 0, prev_last = 0, prev_abort = 0;
    logic [DW-1:0] prev_dout = '0;

    typedef struct {
        int tgt; int to; int cap; int step; int mode; int restart; int exp_words; int exp_to;
    } vec_t;
    vec_t tbl[8];

    function automatic void check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    endfunction

    function automatic logic [31:0] word_of(input int r, input int idx, input int sel);
        return 32'(r * (1 << 24) + idx * 256 + sel);
    endfunction

    function automatic int prof_v(input int k, input int cap, input int step);
        int v;
        v = k / step;
        return (v > cap) ? cap : v;
    endfunction

    // Capture outcome straight from the rules: stop on target/full buffer, else on the timeout-th cycle.
    task automatic model(input int tgt, input int to, input int cap, input int step,
                         output int cnt, output int tmo);
        int t, s;
        t = (tgt == 0) ? 15 : tgt;
        cnt = -1;
        tmo = 0;
        for (int k = 0; k < 70000 && cnt < 0; k++) begin
            s = prof_v(k, cap, step);
            if (s >= t || s == 15) cnt = (s < t) ? s : t;
            else if (to != 0 && k + 1 == to) begin
                cnt = s;
                tmo = 1;
            end
        end
    endtask

    // Core model: one-cycle read latency, sample counter held at zero under rst_soft.
    always @(posedge clk) value <= word_of(run_id, int'(index), int'(value_select));

    always @(posedge clk) begin
        #1;
        if (rst_soft) begin
            cap_k   = 0;
            samples = '0;
        end else begin
            samples = BW'(prof_v(cap_k, cap_q, step_q));
            if (cap_k < 100000) cap_k++;
        end
        case (rdy_mode)
            0: dout_ready = 1'b1;
            1: dout_ready = 1'($urandom_range(0, 1));
            2: if (got_dat.size() == 2 && stall_left > 0 && dout_valid) begin
                   dout_ready = 1'b0;
                   stall_left--;
               end else dout_ready = 1'b1;
            default: dout_ready = (got_dat.size() < 2);
        endcase
    end

    always @(negedge clk) begin
        if (rst_soft) rs_cycles++;
        if (done) done_cnt++;
        if (prev_stall && rst_n && !prev_abort) begin
            check("hold_valid", 64'(dout_valid), 64'(1));
            check("hold_dout", 64'(dout), 64'(prev_dout));
            check("hold_last", 64'(dout_last), 64'(prev_last));
        end
        prev_stall = dout_valid && !dout_ready;
        prev_dout  = dout;
        prev_last  = dout_last;
        prev_abort = abort;
        if (dout_valid && dout_ready && rst_n) begin
            got_dat.push_back(dout);
            got_last.push_back(dout_last);
        end
    end

    task automatic launch(input int tgt, input int to, input int cap, input int step, input int mode);
        run_id++;
        cap_q = cap;
        step_q = step;
        rdy_mode = mode;
        stall_left = 5;
        @(posedge clk); #1;
        got_dat.delete();
        got_last.delete();
        rs_cycles = 0;
        done_cnt = 0;
        start = 1'b1;
        target = BW'(tgt);
        timeout = 16'(to);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_one(input string tag, input vec_t v);
        int cyc;
        launch(v.tgt, v.to, v.cap, v.step, v.mode);
        check({tag, "_busy"}, 64'(busy), 64'(1));
        check({tag, "_to_clr"}, 64'(timed_out), 64'(0));
        cyc = 0;
        while (done !== 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (v.restart != 0) start = (cyc == 10);
        end
        start = 1'b0;
        check({tag, "_done"}, 64'(done), 64'(1));
        @(negedge clk);
        check({tag, "_done_1cyc"}, 64'(done), 64'(0));
        check({tag, "_idle"}, 64'(busy), 64'(0));
        @(negedge clk);
        check({tag, "_nwords"}, 64'(got_dat.size()), 64'(v.exp_words));
        check({tag, "_timed_out"}, 64'(timed_out), 64'(v.exp_to));
        check({tag, "_rst_soft_len"}, 64'(rs_cycles), 64'(CLR));
        check({tag, "_done_cnt"}, 64'(done_cnt), 64'(1));
        for (int i = 0; i < got_dat.size() && i < v.exp_words; i++) begin
            check($sformatf("%s_word%0d", tag, i), 64'(got_dat[i]), 64'(word_of(run_id, i / 2, i % 2)));
            check($sformatf("%s_last%0d", tag, i), 64'(got_last[i]), 64'(i == v.exp_words - 1));
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rst_soft"}, 64'(rst_soft), 64'(0));
        check({tag, "_dout_valid"}, 64'(dout_valid), 64'(0));
        check({tag, "_dout_last"}, 64'(dout_last), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_timed_out"}, 64'(timed_out), 64'(0));
        check({tag, "_index"}, 64'(index), 64'(0));
        check({tag, "_sel"}, 64'(value_select), 64'(0));
        check({tag, "_dout"}, 64'(dout), 64'(0));
    endtask

    initial begin
        vec_t v;
        int cyc, cnt, tmo;
        logic to_before;

        //          tgt to  cap step mode rst words to
        tbl[0] = '{3,  0,  3,  1,   0,   0,  6,  0};
        tbl[1] = '{3,  0,  3,  1,   2,   0,  6,  0};
        tbl[2] = '{8,  20, 2,  1,   0,   0,  4,  1};
        tbl[3] = '{8,  10, 0,  1,   1,   0,  0,  1};
        tbl[4] = '{0,  0,  15, 1,   1,   0,  30, 0};
        tbl[5] = '{5,  0,  9,  2,   0,   1,  10, 0};
        tbl[6] = '{4,  3,  15, 1,   0,   0,  4,  1};
        tbl[7] = '{1,  0,  15, 3,   1,   0,  2,  0};

        #1 rst_n = 1'b0;
        #2 check_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_one($sformatf("vec%0d", i), tbl[i]);

        // Abort while the third word waits in SEND, then a clean rerun.
        launch(3, 0, 3, 1, 3);
        cyc = 0;
        while (!(dout_valid === 1'b1 && got_dat.size() >= 2) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_reached_word2", 64'(got_dat.size()), 64'(2));
        to_before = timed_out;
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        check("abort_valid", 64'(dout_valid), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_rst_soft", 64'(rst_soft), 64'(0));
        check("abort_timed_out", 64'(timed_out), 64'(to_before));
        repeat (6) @(negedge clk);
        check("abort_no_done", 64'(done_cnt), 64'(0));
        check("abort_nwords", 64'(got_dat.size()), 64'(2));
        run_one("post_abort", tbl[0]);

        // Abort wins over a simultaneous start.
        @(posedge clk); #1 begin start = 1'b1; abort = 1'b1; end
        @(posedge clk); #1 begin start = 1'b0; abort = 1'b0; end
        check("prio_busy", 64'(busy), 64'(0));
        check("prio_rst_soft", 64'(rst_soft), 64'(0));

        for (int r = 0; r < 10; r++) begin
            v.tgt = int'($urandom_range(0, 15));
            v.cap = int'($urandom_range(0, 15));
            v.step = int'($urandom_range(1, 3));
            v.to = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 40));
            model(v.tgt, v.to, v.cap, v.step, cnt, tmo);
            if (cnt < 0) begin
                v.to = int'($urandom_range(1, 40));
                model(v.tgt, v.to, v.cap, v.step, cnt, tmo);
            end
            v.mode = 1;
            v.restart = 0;
            v.exp_words = 2 * cnt;
            v.exp_to = tmo;
            run_one($sformatf("rnd%0d", r), v);
        end

        // Asynchronous reset in the middle of CAPTURE.
        launch(0, 0, 15, 4, 0);
        repeat (8) @(posedge clk);
        #1;
        check("midcap_in_capture", 64'({busy, rst_soft}), 64'(2'b10));
        #2 rst_n = 1'b0;
        #1 check_zero("midcap_reset");
        done_cnt = 0;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("midcap_no_done", 64'(done_cnt), 64'(0));
        check("midcap_idle", 64'(busy), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
